// File: rtl/sat_arith_pkg.sv
// Shared saturating-arithmetic helpers for the add/sub datapath.
package sat_arith_pkg;

  localparam int unsigned MAX_W = 64;

  // Flag pair reported alongside a clamped result.
  typedef struct packed {
    logic sat_pos;
    logic sat_neg;
  } sat_flags_t;

  // Largest positive two's complement value of width w: 0 followed by ones.
  function automatic logic [MAX_W-1:0] sat_max(input int unsigned w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i + 1 < w) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Most negative two's complement value of width w: 1 followed by zeros.
  function automatic logic [MAX_W-1:0] sat_min(input int unsigned w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i + 1 == w) v[i] = 1'b1;
    end
    return v;
  endfunction

  // A w+1 bit result overflows w bits when its top two bits disagree.
  function automatic logic ovf_detect(input logic [MAX_W:0] d, input int unsigned w);
    logic top;
    logic nxt;
    top = 1'b0;
    nxt = 1'b0;
    for (int unsigned i = 0; i <= MAX_W; i++) begin
      if (i == w)     top = d[i];
      if (i + 1 == w) nxt = d[i];
    end
    return top != nxt;
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// Combinational WIDTH+1 -> WIDTH clamp with saturation flags.
module sat_clamp
  import sat_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH:0]   i_d,
  output logic [WIDTH-1:0] o_res_c,
  output sat_flags_t       o_flags_c
);

  logic w_ovf;

  // Clamp toward the sign of the wide result when it does not fit.
  always_comb begin
    o_res_c   = i_d[WIDTH-1:0];
    o_flags_c = '0;
    w_ovf     = ovf_detect((MAX_W+1)'(i_d), WIDTH);
    if (w_ovf) begin
      if (!i_d[WIDTH]) begin
        o_res_c           = WIDTH'(sat_max(WIDTH));
        o_flags_c.sat_pos = 1'b1;
      end else begin
        o_res_c           = WIDTH'(sat_min(WIDTH));
        o_flags_c.sat_neg = 1'b1;
      end
    end
  end

endmodule

// File: rtl/signed_sub_with_saturation_pipe.sv
// Two-stage valid/ready pipeline computing sat(a - b) with an overflow counter.
module signed_sub_with_saturation_pipe
  import sat_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] res,
  output logic             sat_pos,
  output logic             sat_neg,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] sat_count
);

  logic             r_v1;
  logic [WIDTH:0]   r_d1;
  logic             r_v2;
  logic [WIDTH-1:0] r_res;
  sat_flags_t       r_flags;
  logic [CNT_W-1:0] r_cnt;

  logic             w_ready2;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  sat_flags_t       w_flags;
  logic             w_out_xfer;

  assign w_ready2   = !r_v2 || down_ready;
  assign up_ready   = !r_v1 || w_ready2;
  assign w_diff     = {a[WIDTH-1], a} - {b[WIDTH-1], b};
  assign w_out_xfer = r_v2 && down_ready;

  sat_clamp #(.WIDTH(WIDTH)) u_clamp (
    .i_d       (r_d1),
    .o_res_c   (w_res),
    .o_flags_c (w_flags)
  );

  // Stage 1: capture the full-precision difference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
    end else if (up_ready) begin
      r_v1 <= up_valid;
      if (up_valid) r_d1 <= w_diff;
    end
  end

  // Stage 2: clamp and hold the result until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r_res   <= '0;
      r_flags <= '0;
    end else if (w_ready2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_res   <= w_res;
        r_flags <= w_flags;
      end
    end
  end

  // Count delivered saturated results; clear wins, count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clear) begin
      r_cnt <= '0;
    end else if (w_out_xfer && (r_flags.sat_pos || r_flags.sat_neg) && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign down_valid = r_v2;
  assign res        = r_res;
  assign sat_pos    = r_flags.sat_pos;
  assign sat_neg    = r_flags.sat_neg;
  assign sat_count  = r_cnt;

endmodule
